gcd_bin: RTL

GCD_BIN -- requirements
Module: gcd_bin

---
 rtl/gcd_bin.sv | 116 +++++++++++
 1 files changed

// File: rtl/gcd_bin.sv
// Binary (Stein) GCD: strips common factors of two, then reduces odd operands
// by halved subtraction until they meet. No divider or multiplier.
module gcd_bin #(
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             zero_err,
  output logic [CW-1:0]    cycles
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic [CW-1:0]    cycles_inc;

  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    zero_d   = zero_q;
    cycles_d = cycles_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = opa;
          b_d      = opb;
          k_d      = '0;
          cycles_d = '0;
          zero_d   = 1'b0;
          result_d = '0;
          // A zero operand makes the other operand the answer; no iteration needed.
          if (opa == '0 || opb == '0) begin
            state_d  = DONE;
            result_d = opa | opb;
            zero_d   = (opa == '0) && (opb == '0);
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        cycles_d = cycles_inc;
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        cycles_d = cycles_inc;
        if (a_q == b_q) begin
          result_d = a_q << k_q;
          state_d  = DONE;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          // Difference of two odd values is even, so halving it is exact.
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result   = result_q;
  assign zero_err = zero_q;
  assign cycles   = cycles_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q == SHIFT) || (state_q == REDUCE);

endmodule
